// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter.
// FSM states, requester encoding and the default memory depth.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_t;

  localparam int MEM_DEPTH_DEF = 200;

  function automatic owner_t other_of(input owner_t o);
    return (o == FETCH) ? DATA : FETCH;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a tie goes to the
// requester that was not granted last.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] reqs,
  input  owner_t     last_grant,
  output owner_t     grant
);

  // reqs[0] = fetch, reqs[1] = data
  always_comb begin
    grant = FETCH;
    unique case (reqs)
      2'b01:   grant = FETCH;
      2'b10:   grant = DATA;
      2'b11:   grant = other_of(last_grant);
      default: grant = FETCH;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter and sequencer for the single-port
// unified memory: IDLE -> ISSUE -> RESP per access.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_adress,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_out
);

  state_t state, state_n;
  owner_t owner, last_grant;
  owner_t pick, cap_sel;

  logic              cap;
  logic              we;
  logic              err_pending;
  logic              in_range;
  logic              other_req;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] resp_data;

  rr_pick2 u_pick (
    .reqs       ({d_req, if_req}),
    .last_grant (last_grant),
    .grant      (pick)
  );

  assign in_range  = addr < ADDR_W'(MEM_DEPTH);
  assign other_req = (owner == DATA) ? if_req : d_req;
  assign resp_data = (we || err_pending) ? '0 : mem_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // The owner is never re-granted from RESP; only the
  // other side can chain straight into a new ISSUE.
  always_comb begin
    state_n = state;
    cap     = 1'b0;
    cap_sel = FETCH;
    unique case (state)
      IDLE: begin
        if (if_req || d_req) begin
          cap     = 1'b1;
          cap_sel = pick;
          state_n = ISSUE;
        end
      end
      ISSUE: state_n = RESP;
      RESP: begin
        if (other_req) begin
          cap     = 1'b1;
          cap_sel = other_of(owner);
          state_n = ISSUE;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner       <= FETCH;
      last_grant  <= FETCH;
      addr        <= '0;
      we          <= 1'b0;
      wdata       <= '0;
      err_pending <= 1'b0;
    end else begin
      if (cap) begin
        owner <= cap_sel;
        addr  <= (cap_sel == DATA) ? d_addr : if_addr;
        we    <= (cap_sel == DATA) && d_we;
        wdata <= (cap_sel == DATA) ? d_wdata : '0;
      end
      if (state == ISSUE) begin
        last_grant  <= owner;
        err_pending <= !in_range;
      end else if (state == RESP) begin
        err_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    if_valid   = 1'b0;
    if_rdata   = '0;
    d_valid    = 1'b0;
    d_rdata    = '0;
    err        = 1'b0;
    mem_adress = '0;
    mem_data   = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    unique case (state)
      ISSUE: begin
        mem_adress = addr;
        if (in_range) begin
          mem_read  = !we;
          mem_write = we;
          mem_data  = wdata;
        end
      end
      RESP: begin
        err = err_pending;
        if (owner == DATA) begin
          d_valid = 1'b1;
          d_rdata = resp_data;
        end else begin
          if_valid = 1'b1;
          if_rdata = resp_data;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural
// 200-word memory clocked by the same clk.
module tb_mem_arbiter;

  localparam logic [31:0] FV = 32'h2002_0069;
  localparam logic [31:0] DV = 32'hDEAD_BEEF;
  localparam logic [31:0] SV = 32'h0000_0555;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        err;
  logic [31:0] mem_adress;
  logic [31:0] mem_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_out;

  logic [31:0] ram [0:255];

  int errors = 0;
  int checks = 0;

  mem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_valid   (if_valid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_valid    (d_valid),
    .d_rdata    (d_rdata),
    .err        (err),
    .mem_adress (mem_adress),
    .mem_data   (mem_data),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_out    (mem_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (init) begin
      ram[107] <= FV;
      ram[5]   <= SV;
      ram[150] <= 32'h0;
    end else begin
      if (mem_write && mem_adress < 200)
        ram[mem_adress[7:0]] <= mem_data;
      if (mem_read && mem_adress < 200)
        mem_out <= ram[mem_adress[7:0]];
    end
  end

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dd;
    logic        iv;
    logic [31:0] ird;
    logic        dv;
    logic [31:0] drd;
    logic        er;
    logic        rd;
    logic        wr;
    logic [31:0] adr;
    logic [31:0] md;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia,
    input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] dd,
    input logic iv, input logic [31:0] ird,
    input logic dv, input logic [31:0] drd,
    input logic er, input logic rd, input logic wr,
    input logic [31:0] adr, input logic [31:0] md);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw;
    v.da = da; v.dd = dd; v.iv = iv; v.ird = ird;
    v.dv = dv; v.drd = drd; v.er = er; v.rd = rd;
    v.wr = wr; v.adr = adr; v.md = md;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_strobes"}, {30'd0, mem_read, mem_write}, 0);
    chk({nm, "_valids"}, {29'd0, if_valid, d_valid, err}, 0);
    chk({nm, "_adr"}, mem_adress, 0);
    chk({nm, "_mdata"}, mem_data, 0);
    chk({nm, "_rdata"}, if_rdata | d_rdata, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dvc, ivc, nv, nd, nf, prev;
    int bad_strobe, bad_alt, bad_data;
    logic [31:0] got;
    bit seen_f, seen_d;

    reset = 1'b1; init = 1'b1;
    if_req = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    @(negedge clk);
    reset = 1'b0; init = 1'b0;
    step();

    vq.push_back(mk(1,107,0,0,0,0,  0,0,0,0,0, 1,0,107,0));
    vq.push_back(mk(1,107,0,0,0,0,  1,FV,0,0,0, 0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk(0,0,1,1,150,DV, 0,0,0,0,0, 0,1,150,DV));
    vq.push_back(mk(0,0,1,1,150,DV, 0,0,1,0,0, 0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk(0,0,1,0,150,0,  0,0,0,0,0, 1,0,150,0));
    vq.push_back(mk(0,0,1,0,150,0,  0,0,1,DV,0, 0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk(0,0,1,0,200,0,  0,0,0,0,0, 0,0,200,0));
    vq.push_back(mk(0,0,1,0,200,0,  0,0,1,0,1, 0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk(0,0,1,0,107,0,  0,0,0,0,0, 1,0,107,0));
    vq.push_back(mk(0,0,0,1,150,1,  0,0,1,FV,0, 0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 0,0,0,0));
    vq.push_back(mk(1,5,1,0,150,0,  0,0,0,0,0, 1,0,5,0));
    vq.push_back(mk(1,5,1,0,150,0,  1,SV,0,0,0, 0,0,0,0));
    vq.push_back(mk(0,5,1,0,150,0,  0,0,0,0,0, 1,0,150,0));
    vq.push_back(mk(0,0,1,0,150,0,  0,0,1,DV,0, 0,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,    0,0,0,0,0, 0,0,0,0));

    foreach (vq[k]) begin
      if_req = vq[k].ir; if_addr = vq[k].ia;
      d_req = vq[k].dr; d_we = vq[k].dw;
      d_addr = vq[k].da; d_wdata = vq[k].dd;
      step();
      chk($sformatf("v%0d_if_valid", k), {31'd0, if_valid}, {31'd0, vq[k].iv});
      chk($sformatf("v%0d_if_rdata", k), if_rdata, vq[k].ird);
      chk($sformatf("v%0d_d_valid", k), {31'd0, d_valid}, {31'd0, vq[k].dv});
      chk($sformatf("v%0d_d_rdata", k), d_rdata, vq[k].drd);
      chk($sformatf("v%0d_err", k), {31'd0, err}, {31'd0, vq[k].er});
      chk($sformatf("v%0d_mem_read", k), {31'd0, mem_read}, {31'd0, vq[k].rd});
      chk($sformatf("v%0d_mem_write", k), {31'd0, mem_write}, {31'd0, vq[k].wr});
      chk($sformatf("v%0d_mem_adress", k), mem_adress, vq[k].adr);
      chk($sformatf("v%0d_mem_data", k), mem_data, vq[k].md);
    end

    // tie right after reset: data first, fetch 2 cycles later
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    step();
    if_req = 1; if_addr = 107;
    d_req = 1; d_we = 0; d_addr = 150;
    dvc = -1; ivc = -1;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (d_valid && dvc < 0) begin
        dvc = c; d_req = 0;
        chk("tie_d_rdata", d_rdata, DV);
      end
      if (if_valid && ivc < 0) begin
        ivc = c; if_req = 0;
        chk("tie_if_rdata", if_rdata, FV);
      end
    end
    chk("tie_d_cycle", dvc, 2);
    chk("tie_if_cycle", ivc, 4);

    // sustained contention, 10 accesses
    nv = 0; nd = 0; nf = 0; prev = -1;
    bad_strobe = 0; bad_alt = 0; bad_data = 0;
    if_req = 1; d_req = 1;
    for (int c = 0; c < 80 && nv < 10; c++) begin
      step();
      if (mem_read && mem_write) bad_strobe++;
      if (d_valid) begin
        if (prev == 1) bad_alt++;
        if (d_rdata !== DV) bad_data++;
        prev = 1; nd++; nv++;
      end
      if (if_valid) begin
        if (prev == 0) bad_alt++;
        if (if_rdata !== FV) bad_data++;
        prev = 0; nf++; nv++;
      end
      if_req = !if_valid;
      d_req  = !d_valid;
    end
    if_req = 0; d_req = 0;
    chk("cont_total", nv, 10);
    chk("cont_data_cnt", nd, 5);
    chk("cont_fetch_cnt", nf, 5);
    chk("cont_alternate", bad_alt, 0);
    chk("cont_strobes", bad_strobe, 0);
    chk("cont_rdata", bad_data, 0);
    repeat (4) step();
    chk_idle("drain");

    // async reset during ISSUE of a load
    d_req = 1; d_we = 0; d_addr = 150;
    step();
    chk("rst_issue_read", {31'd0, mem_read}, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_idle("rst_mid");
    d_req = 0;
    if_req = 1; if_addr = 107;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen_f = 0; seen_d = 0; got = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (d_valid) seen_d = 1;
      if (if_valid && !seen_f) begin
        seen_f = 1; got = if_rdata; if_req = 0;
      end
    end
    chk("rst_no_d_valid", {31'd0, seen_d}, 0);
    chk("rst_fetch_done", {31'd0, seen_f}, 1);
    chk("rst_fetch_rdata", got, FV);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
